// File: rtl/cpu_pkg.sv
// Shared types and defaults for the scalar/vector core.
// Imported by fetch_stage and fetch_perf_counter.
package cpu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned PERF_W  = 32;

    localparam int unsigned DEFAULT_PC_STEP  = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// Saturating event counter used for fetch statistics.
// Holds at all-ones once it gets there.
module fetch_perf_counter
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    output logic [PERF_W-1:0] count
);

    // count enabled events, stop at the top value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + PERF_W'(1);
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, 1-cycle imem request, IF/ID register.
// Define FETCH_PERF_EN to add FETCH_COUNT / BUBBLE_COUNT outputs.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned      PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               STALL,
    input  logic               BRANCH_TAKEN,
    input  logic [WIDTH-1:0]   BRANCH_TARGET,
    output logic [WIDTH-1:0]   IMEM_ADDR,
    input  logic [INSTR_W-1:0] IMEM_RDATA,
    output logic [INSTR_W-1:0] INSTR,
    output logic [WIDTH-1:0]   INSTR_PC,
    output logic               INSTR_VALID,
    output logic [IMM_W-1:0]   IMM
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_W-1:0]  FETCH_COUNT,
    output logic [PERF_W-1:0]  BUBBLE_COUNT
`endif
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] req_pc_q;
    logic             req_valid_q;
    instr_t           instr_q;
    logic [WIDTH-1:0] instr_pc_q;
    logic             valid_q;

    logic             advance;
    logic [WIDTH-1:0] target;
    logic             unused_tgt;

    assign advance    = !BRANCH_TAKEN && !STALL;
    assign target     = {BRANCH_TARGET[WIDTH-1:2], 2'b00};
    assign unused_tgt = ^BRANCH_TARGET[1:0];

    // On a stall re-issue the in-flight address so rdata stays valid
    assign IMEM_ADDR = STALL ? req_pc_q : pc_q;

    assign INSTR       = instr_q;
    assign INSTR_PC    = instr_pc_q;
    assign INSTR_VALID = valid_q;
    assign IMM         = instr_q[IMM_W-1:0];

    // fetch pointer and the request currently in memory
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else if (BRANCH_TAKEN) begin
            pc_q        <= target;
            req_valid_q <= 1'b0;
        end else if (!STALL) begin
            req_pc_q    <= pc_q;
            req_valid_q <= 1'b1;
            pc_q        <= pc_q + WIDTH'(PC_STEP);
        end
    end

    // IF/ID register; a redirect flushes it but keeps the old PC
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else if (BRANCH_TAKEN) begin
            instr_q <= '0;
            valid_q <= 1'b0;
        end else if (!STALL) begin
            instr_q    <= IMEM_RDATA;
            instr_pc_q <= req_pc_q;
            valid_q    <= req_valid_q;
        end
    end

`ifdef FETCH_PERF_EN
    logic fetch_inc;
    logic bubble_inc;

    assign fetch_inc  = advance && req_valid_q;
    assign bubble_inc = BRANCH_TAKEN || (advance && !req_valid_q);

    fetch_perf_counter u_fetch_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (fetch_inc),
        .count (FETCH_COUNT)
    );

    fetch_perf_counter u_bubble_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (bubble_inc),
        .count (BUBBLE_COUNT)
    );
`else
    logic unused_adv;
    assign unused_adv = advance;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage (default build).
// Expected words come from a bench-side memory pattern.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = '0;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA = '0;
    logic [31:0] INSTR;
    logic [31:0] INSTR_PC;
    logic        INSTR_VALID;
    logic [15:0] IMM;

    logic        rst_w = 1'b0;
    logic [31:0] w_addr;
    logic [31:0] w_rdata = '0;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_valid;
    logic [15:0] w_imm;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 CLK = ~CLK;

    fetch_stage u_dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_RDATA    (IMEM_RDATA),
        .INSTR         (INSTR),
        .INSTR_PC      (INSTR_PC),
        .INSTR_VALID   (INSTR_VALID),
        .IMM           (IMM)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .CLK           (CLK),
        .RST_N         (rst_w),
        .STALL         (1'b0),
        .BRANCH_TAKEN  (1'b0),
        .BRANCH_TARGET (32'h0),
        .IMEM_ADDR     (w_addr),
        .IMEM_RDATA    (w_rdata),
        .INSTR         (w_instr),
        .INSTR_PC      (w_pc),
        .INSTR_VALID   (w_valid),
        .IMM           (w_imm)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    // synchronous instruction memories, 1-cycle latency
    always @(posedge CLK) begin
        IMEM_RDATA <= word(IMEM_ADDR);
        w_rdata    <= word(w_addr);
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = word(pc);
        sb.push_back(e);
    endtask

    task automatic cycle(input logic st, input logic br,
                         input logic [31:0] tgt);
        logic [31:0] s_instr;
        logic [31:0] s_pc;
        logic        s_v;
        exp_t        e;
        STALL         = st;
        BRANCH_TAKEN  = br;
        BRANCH_TARGET = tgt;
        s_instr = INSTR;
        s_pc    = INSTR_PC;
        s_v     = INSTR_VALID;
        @(posedge CLK);
        #2;
        if (br) begin
            check("flush_valid", INSTR_VALID, 0);
            check("flush_instr", INSTR, 0);
            check("flush_pc_hold", INSTR_PC, s_pc);
        end else if (st) begin
            check("stall_instr", INSTR, s_instr);
            check("stall_pc", INSTR_PC, s_pc);
            check("stall_valid", INSTR_VALID, s_v);
        end else if (INSTR_VALID) begin
            check("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("instr", INSTR, e.instr);
                check("instr_pc", INSTR_PC, e.pc);
                check("imm", IMM, e.instr[15:0]);
            end
        end
        STALL        = 1'b0;
        BRANCH_TAKEN = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #2;
        check("rst_instr", INSTR, 0);
        check("rst_pc", INSTR_PC, 0);
        check("rst_valid", INSTR_VALID, 0);
        check("rst_imm", IMM, 0);
        check("rst_addr", IMEM_ADDR, 0);

        RST_N = 1'b1;
        for (int a = 0; a <= 16; a += 4) push(32'(a));
        cycle(0, 0, 0);
        check("first_e1_valid", INSTR_VALID, 0);
        cycle(0, 0, 0);
        check("first_e2_valid", INSTR_VALID, 1);
        cycle(0, 0, 0);
        cycle(0, 0, 0);

        repeat (3) begin
            STALL = 1'b1;
            #1;
            check("stall_addr", IMEM_ADDR, 32'd12);
            cycle(1, 0, 0);
        end
        #1;
        check("release_addr", IMEM_ADDR, 32'd16);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("sb_empty_stream", 32'(sb.size()), 0);

        push(32'h100);
        push(32'h104);
        cycle(0, 1, 32'h0000_0103);
        cycle(0, 0, 0);
        check("br_bubble2", INSTR_VALID, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("sb_empty_branch", 32'(sb.size()), 0);

        push(32'h200);
        cycle(1, 1, 32'h0000_0200);
        cycle(0, 0, 0);
        check("brst_bubble2", INSTR_VALID, 0);
        cycle(0, 0, 0);
        check("sb_empty_brstall", 32'(sb.size()), 0);
        push(32'h204);
        cycle(0, 0, 0);

        #1;
        RST_N = 1'b0;
        #1;
        check("arst_instr", INSTR, 0);
        check("arst_pc", INSTR_PC, 0);
        check("arst_valid", INSTR_VALID, 0);
        check("arst_imm", IMM, 0);
        #1;
        RST_N = 1'b1;
        push(32'h0);
        push(32'h4);
        cycle(0, 0, 0);
        check("arst_e1_valid", INSTR_VALID, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("sb_empty_arst", 32'(sb.size()), 0);

        RST_N = 1'b0;
        @(posedge CLK);
        #2;
        rst_w = 1'b1;
        @(posedge CLK);
        #2;
        check("wrap_e1_valid", w_valid, 0);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ep;
            ep = 32'hFFFF_FFF8 + 32'(4 * k);
            @(posedge CLK);
            #2;
            check("wrap_valid", w_valid, 1);
            check("wrap_pc", w_pc, ep);
            check("wrap_instr", w_instr, word(ep));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
